// File: rtl/scr_1dim_pkg.sv
// Shared definitions for the 7-bit additive scrambler/descrambler pair.
// Both ends use scr_step so the polynomial lives in exactly one place.
package scr_1dim_pkg;

  localparam int SCR_WIDTH = 7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } descr_state_t;

  function automatic logic [SCR_WIDTH-1:0] scr_step(input logic [SCR_WIDTH-1:0] r);
    return {r[5], r[4] ^ r[3], r[3], r[2], r[1], r[0], r[5] ^ r[6]};
  endfunction

  // Seven consecutive keystream bits (h[0] newest) pin down the current state.
  function automatic logic [SCR_WIDTH-1:0] scr_state_from_hist(input logic [SCR_WIDTH-1:0] h);
    return {h[6] ^ h[5], h[5] ^ h[4], h[4:0]};
  endfunction

endpackage

// File: rtl/scr_1dim_lfsr.sv
// Keystream LFSR: load or advance, k is the bit produced by the next advance.
// Latency 0 on k (combinational from state); no backpressure, advance is strobed.
module scr_1dim_lfsr
  import scr_1dim_pkg::*;
(
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic                 load,
  input  logic [SCR_WIDTH-1:0] load_val,
  input  logic                 adv,
  output logic                 k
);

  logic [SCR_WIDTH-1:0] r_q, r_d;
  logic [SCR_WIDTH-1:0] r_nxt;

  assign r_nxt = scr_step(r_q);
  assign k     = r_nxt[0];

  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = load_val;
    end else if (adv) begin
      r_d = r_nxt;
    end
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/scr_1dim_descr.sv
// Receive-side 7-bit additive descrambler with seed load or preamble hunt/verify lock.
// Latency 1 cycle data_in -> data_out; no backpressure, one bit per data_in_en.
module scr_1dim_descr #(
  parameter int DATA_WIDTH = 1,
  parameter int SCR_WIDTH  = 7,
  parameter int VERIFY_LEN = 32,
  parameter int HUNT_LEN   = 7
) (
  input  logic                  clk,
  input  logic                  kill_n,
  input  logic                  descr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_en,
  input  logic [SCR_WIDTH-1:0]  init_val,
  input  logic                  init_val_en,
  input  logic                  resync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_en,
  output logic                  locked,
  output logic                  verify_err
);
  import scr_1dim_pkg::*;

  localparam int HCW = $clog2(HUNT_LEN + 1);

  descr_state_t          state_q, state_d;
  logic [SCR_WIDTH-1:0]  hist_q, hist_d, hist_nxt;
  logic [HCW-1:0]        hunt_cnt_q, hunt_cnt_d;
  logic [7:0]            vcnt_q, vcnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_out_en_q, data_out_en_d;
  logic                  verify_err_q, verify_err_d;
  logic                  lfsr_load, lfsr_adv, lfsr_k;
  logic [SCR_WIDTH-1:0]  lfsr_load_val;

  assign hist_nxt = {hist_q[SCR_WIDTH-2:0], data_in[0]};

  scr_1dim_lfsr u_lfsr (
    .clk      (clk),
    .kill_n   (kill_n),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .adv      (lfsr_adv),
    .k        (lfsr_k)
  );

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    hunt_cnt_d    = hunt_cnt_q;
    vcnt_d        = vcnt_q;
    lfsr_load     = 1'b0;
    lfsr_load_val = init_val;
    lfsr_adv      = 1'b0;
    data_out_d    = '0;
    data_out_en_d = 1'b0;
    verify_err_d  = 1'b0;

    // Seed load beats resync; both throw away the bit arriving that cycle.
    if (init_val_en) begin
      state_d    = LOCKED;
      lfsr_load  = 1'b1;
      hist_d     = '0;
      hunt_cnt_d = '0;
      vcnt_d     = '0;
    end else if (resync) begin
      state_d    = HUNT;
      hist_d     = '0;
      hunt_cnt_d = '0;
      vcnt_d     = '0;
    end else if (data_in_en) begin
      case (state_q)
        HUNT: begin
          hist_d = hist_nxt;
          if (hunt_cnt_q == HCW'(HUNT_LEN - 1)) begin
            lfsr_load     = 1'b1;
            lfsr_load_val = scr_state_from_hist(hist_nxt);
            state_d       = VERIFY;
            hunt_cnt_d    = '0;
            vcnt_d        = '0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + HCW'(1);
          end
        end
        VERIFY: begin
          lfsr_adv = 1'b1;
          if (data_in[0] != lfsr_k) begin
            verify_err_d = 1'b1;
            state_d      = HUNT;
            hist_d       = '0;
            hunt_cnt_d   = '0;
            vcnt_d       = '0;
          end else if (vcnt_q == 8'(VERIFY_LEN - 1)) begin
            state_d = LOCKED;
            vcnt_d  = '0;
          end else begin
            vcnt_d = vcnt_q + 8'd1;
          end
        end
        LOCKED: begin
          lfsr_adv      = 1'b1;
          data_out_en_d = 1'b1;
          data_out_d    = DATA_WIDTH'(data_in[0] ^ (descr_en & lfsr_k));
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q       <= HUNT;
      hist_q        <= '0;
      hunt_cnt_q    <= '0;
      vcnt_q        <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      verify_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      hunt_cnt_q    <= hunt_cnt_d;
      vcnt_q        <= vcnt_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      verify_err_q  <= verify_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_out_en = data_out_en_q;
  assign locked      = (state_q == LOCKED);
  assign verify_err  = verify_err_q;

endmodule
